// File: rtl/i2s_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Desc     : Shared constants and FSM encoding for the I2S transmit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned SLOT_W_DEF = 32;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_bck_gen.sv
// ============================================================================
// Module   : i2s_bck_gen
// Desc     : Bit-clock divider; registered BCK plus a strobe on each BCK fall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_bck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bck,
    output logic o_fall_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [DIV_W-1:0] divcnt_q, divcnt_d;
    logic             bck_q, bck_d;
    logic             w_wrap;

    assign w_wrap = (divcnt_q == DIV_MAX);

    always_comb begin
        divcnt_d = divcnt_q;
        bck_d    = bck_q;
        if (!i_run) begin
            divcnt_d = '0;
            bck_d    = 1'b0;
        end else if (w_wrap) begin
            divcnt_d = '0;
            bck_d    = ~bck_q;
        end else begin
            divcnt_d = divcnt_q + DIV_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divcnt_q <= '0;
            bck_q    <= 1'b0;
        end else begin
            divcnt_q <= divcnt_d;
            bck_q    <= bck_d;
        end
    end

    assign o_bck       = bck_q;
    // Strobe is valid in the same cycle the register is about to go 1->0.
    assign o_fall_tick = i_run & w_wrap & bck_q;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_master.sv
// ============================================================================
// Module   : i2s_tx_master
// Desc     : I2S master transmitter, 24-bit stereo, valid/ready sample input.
//            Optional macro I2S_TX_UNDERRUN_MUTE_EN: mute + sticky flag on underrun.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_master
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLOT_W  = SLOT_W_DEF,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              iSysClk,
    input  logic              iReset,
    input  logic              iEnable,
    input  logic [DATA_W-1:0] iDataL,
    input  logic [DATA_W-1:0] iDataR,
    input  logic              iValid,
    output logic              oReady,
    output logic              oBCK,
    output logic              oLRCK,
    output logic              oDataOut,
    output logic              oFrameStart,
    output logic              oUnderrun
);

    localparam int unsigned CNT_W = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] SLOT_MAX      = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] LAST_DATA_POS = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              lrck_q, lrck_d;
    logic              data_q, data_d;
    logic              frame_start_q, frame_start_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] shift_l_q, shift_l_d;
    logic [DATA_W-1:0] shift_r_q, shift_r_d;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    logic              underrun_q, underrun_d;
`else
    logic [DATA_W-1:0] last_l_q, last_l_d;
    logic [DATA_W-1:0] last_r_q, last_r_d;
`endif

    logic w_fall_tick;
    logic w_run;

    assign w_run = (state_q == ST_RUN);

    i2s_bck_gen #(
        .CLK_DIV     (CLK_DIV)
    ) u_bck_gen (
        .clk         (iSysClk),
        .rst         (iReset),
        .i_run       (w_run),
        .o_bck       (oBCK),
        .o_fall_tick (w_fall_tick)
    );

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        lrck_d        = lrck_q;
        data_d        = data_q;
        frame_start_d = 1'b0;
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        underrun_d    = underrun_q;
`else
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
`endif

        // Acceptance only when empty, so it can never collide with a transfer.
        if (iValid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_l_d    = iDataL;
            hold_r_d    = iDataR;
        end

        case (state_q)
            ST_IDLE: begin
                lrck_d = LRCK_RIGHT;
                data_d = 1'b0;
                if (iEnable) begin
                    state_d  = ST_RUN;
                    bitcnt_d = SLOT_MAX;
                end
            end
            ST_RUN: begin
                if (w_fall_tick) begin
                    if (bitcnt_q == SLOT_MAX) begin
                        data_d = 1'b0;
                        if (lrck_q == LRCK_LEFT) begin
                            lrck_d   = LRCK_RIGHT;
                            bitcnt_d = '0;
                        end else if (!iEnable) begin
                            state_d = ST_IDLE;
                        end else begin
                            frame_start_d = 1'b1;
                            lrck_d        = LRCK_LEFT;
                            bitcnt_d      = '0;
                            if (hold_full_q) begin
                                hold_full_d = 1'b0;
                                shift_l_d   = hold_l_q;
                                shift_r_d   = hold_r_q;
`ifndef I2S_TX_UNDERRUN_MUTE_EN
                                last_l_d    = hold_l_q;
                                last_r_d    = hold_r_q;
`endif
                            end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                                shift_l_d  = '0;
                                shift_r_d  = '0;
                                underrun_d = 1'b1;
`else
                                shift_l_d  = last_l_q;
                                shift_r_d  = last_r_q;
`endif
                            end
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_ONE;
                        // Positions 1..DATA_W carry the word, MSB first.
                        if (bitcnt_q <= LAST_DATA_POS) begin
                            if (lrck_q == LRCK_LEFT) begin
                                data_d    = shift_l_q[DATA_W-1];
                                shift_l_d = {shift_l_q[DATA_W-2:0], 1'b0};
                            end else begin
                                data_d    = shift_r_q[DATA_W-1];
                                shift_r_d = {shift_r_q[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            data_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (iReset) begin
            state_q       <= ST_IDLE;
            bitcnt_q      <= '0;
            lrck_q        <= LRCK_RIGHT;
            data_q        <= 1'b0;
            frame_start_q <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            underrun_q    <= 1'b0;
`else
            last_l_q      <= '0;
            last_r_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            lrck_q        <= lrck_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            underrun_q    <= underrun_d;
`else
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
`endif
        end
    end

    assign oReady      = ~hold_full_q;
    assign oLRCK       = lrck_q;
    assign oDataOut    = data_q;
    assign oFrameStart = frame_start_q;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    assign oUnderrun   = underrun_q;
`else
    assign oUnderrun   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_master.sv
// ============================================================================
// Module   : tb_i2s_tx_master
// Desc     : Self-checking bench; an I2S receiver model decodes the serial line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx_master;

    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 2 * SLOT_W * 2 * CLK_DIV;

    logic              sys_clk = 1'b0;
    logic              reset   = 1'b1;
    logic              enable  = 1'b0;
    logic [DATA_W-1:0] data_l  = '0;
    logic [DATA_W-1:0] data_r  = '0;
    logic              valid   = 1'b0;
    logic              ready;
    logic              bck;
    logic              lrck;
    logic              sdata;
    logic              frame_start;
    logic              underrun;

    int n_tests = 0;
    int n_fail  = 0;

    i2s_tx_master #(
        .DATA_W      (DATA_W),
        .SLOT_W      (SLOT_W),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .iSysClk     (sys_clk),
        .iReset      (reset),
        .iEnable     (enable),
        .iDataL      (data_l),
        .iDataR      (data_r),
        .iValid      (valid),
        .oReady      (ready),
        .oBCK        (bck),
        .oLRCK       (lrck),
        .oDataOut    (sdata),
        .oFrameStart (frame_start),
        .oUnderrun   (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Receiver model and line monitor, sampled mid-cycle on the falling edge.
    int                cyc = 0;
    int                edge_viol = 0;
    int                fs_err = 0;
    int                pad_err = 0;
    int                fs_count = 0;
    int                fs_times[$];
    logic [DATA_W-1:0] rx_l_q[$];
    logic [DATA_W-1:0] rx_r_q[$];
    logic              p_bck = 1'b0, p_lrck = 1'b1, p_data = 1'b0;
    logic              armed = 1'b0;
    logic              rx_lrck = 1'b1;
    int                rx_pos = 0;
    logic [DATA_W-1:0] rx_word = '0;
    logic [DATA_W-1:0] rx_left = '0;
    logic              got_left = 1'b0;

    always @(negedge sys_clk) begin
        cyc++;
        if (reset) begin
            armed    = 1'b0;
            rx_lrck  = 1'b1;
            rx_pos   = 0;
            got_left = 1'b0;
        end else begin
            if (armed) begin
                if ((lrck !== p_lrck || sdata !== p_data) && !(p_bck === 1'b1 && bck === 1'b0))
                    edge_viol++;
                if (frame_start !== (p_lrck === 1'b1 && lrck === 1'b0))
                    fs_err++;
                if (p_bck === 1'b0 && bck === 1'b1) begin
                    if (lrck !== rx_lrck) begin
                        rx_lrck = lrck;
                        rx_pos  = 0;
                    end
                    if (rx_pos == 0 || rx_pos > DATA_W) begin
                        if (sdata !== 1'b0) pad_err++;
                    end else begin
                        rx_word = {rx_word[DATA_W-2:0], sdata};
                    end
                    if (rx_pos == DATA_W) begin
                        if (rx_lrck == 1'b0) begin
                            rx_left  = rx_word;
                            got_left = 1'b1;
                        end else if (got_left) begin
                            rx_l_q.push_back(rx_left);
                            rx_r_q.push_back(rx_word);
                            got_left = 1'b0;
                        end
                    end
                    rx_pos++;
                end
            end
            if (frame_start === 1'b1) begin
                fs_times.push_back(cyc);
                fs_count++;
            end
            armed = 1'b1;
        end
        p_bck  = bck;
        p_lrck = lrck;
        p_data = sdata;
    end

    task automatic clear_mon();
        edge_viol = 0;
        fs_err    = 0;
        pad_err   = 0;
        fs_count  = 0;
        fs_times.delete();
        rx_l_q.delete();
        rx_r_q.delete();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        valid  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        clear_mon();
        @(posedge sys_clk);
        #1;
    endtask

    // Holds the pair on the bus until the DUT takes it; iValid is left asserted.
    task automatic offer_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              output bit ok, output int waited, output logic fs_seen);
        logic rb, fsb;
        data_l  = l;
        data_r  = r;
        valid   = 1'b1;
        ok      = 1'b0;
        waited  = 0;
        fs_seen = 1'b0;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            rb  = ready;
            fsb = frame_start;
            @(posedge sys_clk);
            #1;
            if (rb === 1'b1) begin
                ok      = 1'b1;
                fs_seen = fsb;
                break;
            end
            waited++;
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_l_q.size() < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bit   ok;
        int   w;
        logic fs;
        reset = 1'b1; enable = 1'b0; valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_tests += 6;
        if (bck !== 1'b0)         begin n_fail++; $display("FAIL por_bck got %b want 0", bck); end
        if (lrck !== 1'b1)        begin n_fail++; $display("FAIL por_lrck got %b want 1", lrck); end
        if (sdata !== 1'b0)       begin n_fail++; $display("FAIL por_data got %b want 0", sdata); end
        if (ready !== 1'b1)       begin n_fail++; $display("FAIL por_ready got %b want 1", ready); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL por_fs got %b want 0", frame_start); end
        if (underrun !== 1'b0)    begin n_fail++; $display("FAIL por_underrun got %b want 0", underrun); end

        reset = 1'b0;
        offer_pair(DATA_W'($urandom), DATA_W'($urandom), ok, w, fs);
        enable = 1'b1;
        offer_pair(DATA_W'($urandom), DATA_W'($urandom), ok, w, fs);
        valid = 1'b0;
        repeat (60) @(posedge sys_clk);
        #1;
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        n_tests += 6;
        if (bck !== 1'b0)         begin n_fail++; $display("FAIL rst_bck got %b want 0", bck); end
        if (lrck !== 1'b1)        begin n_fail++; $display("FAIL rst_lrck got %b want 1", lrck); end
        if (sdata !== 1'b0)       begin n_fail++; $display("FAIL rst_data got %b want 0", sdata); end
        if (ready !== 1'b1)       begin n_fail++; $display("FAIL rst_ready got %b want 1", ready); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs got %b want 0", frame_start); end
        if (underrun !== 1'b0)    begin n_fail++; $display("FAIL rst_underrun got %b want 0", underrun); end
        repeat (2) @(posedge sys_clk);
        #1;
        enable = 1'b0;
        reset  = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        n_tests += 2;
        if (bck !== 1'b0)  begin n_fail++; $display("FAIL idle_bck got %b want 0", bck); end
        if (lrck !== 1'b1) begin n_fail++; $display("FAIL idle_lrck got %b want 1", lrck); end
    endtask

    task automatic test_single_pair();
        bit   ok;
        int   w;
        logic fs;
        do_reset();
        offer_pair(24'hA72D00, 24'h2F6D00, ok, w, fs);
        valid = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_accept got timeout want accept"); end
        enable = 1'b1;
        wait_rx(1, 3 * FRAME_CYC);
        n_tests++;
        if (rx_l_q.size() < 1) begin
            n_fail++; $display("FAIL single_rx got %0d frames want 1", rx_l_q.size());
        end else begin
            n_tests += 2;
            if (rx_l_q[0] !== 24'hA72D00) begin n_fail++; $display("FAIL single_left got %h want a72d00", rx_l_q[0]); end
            if (rx_r_q[0] !== 24'h2F6D00) begin n_fail++; $display("FAIL single_right got %h want 2f6d00", rx_r_q[0]); end
        end
        n_tests += 2;
        if (pad_err != 0)   begin n_fail++; $display("FAIL single_pad got %0d want 0", pad_err); end
        if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        logic [DATA_W-1:0] pl[N];
        logic [DATA_W-1:0] pr[N];
        logic [DATA_W-1:0] exp_l, exp_r;
        bit   ok;
        int   w;
        logic fs;
        do_reset();
        pl[0] = 24'hFFFFFE;
        pr[0] = 24'h000001;
        for (int k = 1; k < N; k++) begin
            pl[k] = DATA_W'($urandom);
            pr[k] = DATA_W'($urandom);
        end
        for (int k = 0; k < N; k++) begin
            offer_pair(pl[k], pr[k], ok, w, fs);
            if (k == 0) enable = 1'b1;
            n_tests += 2;
            if (!ok) begin n_fail++; $display("FAIL b2b_accept[%0d] got timeout want accept", k); end
            if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full[%0d] ready got %b want 0", k, ready); end
            if (k > 0) begin
                n_tests += 2;
                if (w == 0)     begin n_fail++; $display("FAIL b2b_wait[%0d] got %0d cycles want >0", k, w); end
                if (fs !== 1'b1) begin n_fail++; $display("FAIL b2b_boundary[%0d] got fs=%b want 1", k, fs); end
            end
        end
        valid = 1'b0;
        wait_rx(N + 1, (N + 3) * FRAME_CYC);
        n_tests++;
        if (rx_l_q.size() < N + 1) begin
            n_fail++; $display("FAIL b2b_rx got %0d frames want %0d", rx_l_q.size(), N + 1);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_tests += 2;
                if (rx_l_q[k] !== pl[k]) begin n_fail++; $display("FAIL b2b_left[%0d] got %h want %h", k, rx_l_q[k], pl[k]); end
                if (rx_r_q[k] !== pr[k]) begin n_fail++; $display("FAIL b2b_right[%0d] got %h want %h", k, rx_r_q[k], pr[k]); end
            end
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            exp_l = '0;
            exp_r = '0;
`else
            exp_l = pl[N-1];
            exp_r = pr[N-1];
`endif
            n_tests += 2;
            if (rx_l_q[N] !== exp_l) begin n_fail++; $display("FAIL underrun_left got %h want %h", rx_l_q[N], exp_l); end
            if (rx_r_q[N] !== exp_r) begin n_fail++; $display("FAIL underrun_right got %h want %h", rx_r_q[N], exp_r); end
        end
        repeat (FRAME_CYC) @(posedge sys_clk);
        #1;
        n_tests++;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag got %b want 1", underrun); end
`else
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_flag got %b want 0", underrun); end
`endif
    endtask

    task automatic test_timing();
        bit   ok;
        int   w;
        logic fs;
        do_reset();
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL timing_underrun_clr got %b want 0", underrun); end
        offer_pair(DATA_W'($urandom), DATA_W'($urandom), ok, w, fs);
        enable = 1'b1;
        offer_pair(DATA_W'($urandom), DATA_W'($urandom), ok, w, fs);
        valid = 1'b0;
        for (int i = 0; i < 7 * FRAME_CYC && fs_times.size() < 5; i++) begin
            @(posedge sys_clk);
            #1;
        end
        n_tests++;
        if (fs_times.size() < 5) begin
            n_fail++; $display("FAIL timing_fs_count got %0d want 5", fs_times.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_tests++;
                if (fs_times[i] - fs_times[i-1] != FRAME_CYC) begin
                    n_fail++; $display("FAIL timing_period[%0d] got %0d want %0d", i, fs_times[i] - fs_times[i-1], FRAME_CYC);
                end
            end
        end
        n_tests += 3;
        if (edge_viol != 0) begin n_fail++; $display("FAIL timing_edges got %0d changes off BCK fall want 0", edge_viol); end
        if (fs_err != 0)    begin n_fail++; $display("FAIL timing_fs_align got %0d want 0", fs_err); end
        if (pad_err != 0)   begin n_fail++; $display("FAIL timing_pad got %0d want 0", pad_err); end
    endtask

    task automatic test_stop();
        logic [DATA_W-1:0] p_l, p_r, q_l, q_r;
        bit   ok;
        int   w;
        logic fs;
        int   fs_before;
        do_reset();
        p_l = DATA_W'($urandom); p_r = DATA_W'($urandom);
        q_l = DATA_W'($urandom); q_r = DATA_W'($urandom);
        offer_pair(p_l, p_r, ok, w, fs);
        enable = 1'b1;
        offer_pair(q_l, q_r, ok, w, fs);
        valid = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stop_accept got timeout want accept"); end
        repeat (40) @(posedge sys_clk);
        #1;
        enable    = 1'b0;
        fs_before = fs_count;
        wait_rx(1, 2 * FRAME_CYC);
        n_tests++;
        if (rx_l_q.size() < 1) begin
            n_fail++; $display("FAIL stop_complete got %0d frames want 1", rx_l_q.size());
        end else begin
            n_tests += 2;
            if (rx_l_q[0] !== p_l) begin n_fail++; $display("FAIL stop_left got %h want %h", rx_l_q[0], p_l); end
            if (rx_r_q[0] !== p_r) begin n_fail++; $display("FAIL stop_right got %h want %h", rx_r_q[0], p_r); end
        end
        repeat (FRAME_CYC) @(posedge sys_clk);
        #1;
        n_tests += 5;
        if (fs_count != fs_before) begin n_fail++; $display("FAIL stop_no_frame got %0d starts want 0", fs_count - fs_before); end
        if (bck !== 1'b0)   begin n_fail++; $display("FAIL stop_bck got %b want 0", bck); end
        if (lrck !== 1'b1)  begin n_fail++; $display("FAIL stop_lrck got %b want 1", lrck); end
        if (sdata !== 1'b0) begin n_fail++; $display("FAIL stop_data got %b want 0", sdata); end
        if (ready !== 1'b0) begin n_fail++; $display("FAIL stop_held got ready=%b want 0", ready); end
        enable = 1'b1;
        wait_rx(2, 3 * FRAME_CYC);
        n_tests++;
        if (rx_l_q.size() < 2) begin
            n_fail++; $display("FAIL restart_rx got %0d frames want 2", rx_l_q.size());
        end else begin
            n_tests += 2;
            if (rx_l_q[1] !== q_l) begin n_fail++; $display("FAIL restart_left got %h want %h", rx_l_q[1], q_l); end
            if (rx_r_q[1] !== q_r) begin n_fail++; $display("FAIL restart_right got %h want %h", rx_r_q[1], q_r); end
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_timing();
        test_stop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
